// File: rtl/prog_loader.sv
// prog_loader: buffers a big-endian byte stream (count, words[, checksum]) and then bursts it into core imem from 0x8000.
// Two cycles from the last byte to the first pg and from the last pg to done; rx_ready only while receiving. Checksum: PROG_LOADER_CKSUM_EN.
module prog_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        pg,
  output logic [15:0] pg_instr,
  output logic        core_rstz,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef PROG_LOADER_CKSUM_EN
    S_CK_HI,
    S_CK_LO,
`endif
    S_ARM,
    S_BURST,
    S_PARK,
    S_RUN,
    S_ERR
  } state_t;

  state_t      state;
  logic [15:0] n;
  logic [15:0] wr_idx;
  logic [15:0] rd_idx;
  logic [7:0]  hi;
  logic        acc;
  logic [15:0] rx_word;
  logic        rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0] mem [DEPTH];
`ifdef PROG_LOADER_CKSUM_EN
  logic [15:0] sum;
`endif

  assign acc     = rx_valid & rx_ready;
  assign rx_word = {hi, rx_data};

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state     <= S_HDR_HI;
      rx_ready  <= 1'b0;
      pg        <= 1'b0;
      core_rstz <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      n         <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      hi        <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      sum       <= '0;
`endif
    end else begin
      case (state)
        S_HDR_HI: begin
          rx_ready <= 1'b1;
          if (acc) begin
            hi    <= rx_data;
            busy  <= 1'b1;
            state <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (acc) begin
            n      <= rx_word;
            wr_idx <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            sum    <= '0;
`endif
            if (rx_word > 16'(DEPTH)) begin
              state    <= S_ERR;
              err      <= 1'b1;
              busy     <= 1'b0;
              rx_ready <= 1'b0;
            end else if (rx_word == 16'd0) begin
`ifdef PROG_LOADER_CKSUM_EN
              state    <= S_CK_HI;
`else
              state    <= S_ARM;
              rx_ready <= 1'b0;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (acc) begin
            hi    <= rx_data;
            state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (acc) begin
            wr_idx <= wr_idx + 16'd1;
`ifdef PROG_LOADER_CKSUM_EN
            sum    <= sum + rx_word;
`endif
            if (wr_idx + 16'd1 == n) begin
`ifdef PROG_LOADER_CKSUM_EN
              state    <= S_CK_HI;
`else
              state    <= S_ARM;
              rx_ready <= 1'b0;
`endif
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
`ifdef PROG_LOADER_CKSUM_EN
        S_CK_HI: begin
          if (acc) begin
            hi    <= rx_data;
            state <= S_CK_LO;
          end
        end
        S_CK_LO: begin
          if (acc) begin
            rx_ready <= 1'b0;
            if (rx_word == sum) begin
              state <= S_ARM;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
`endif
        S_ARM: begin
          // Word 0 is fetched this cycle, so the burst counter starts at 1.
          rd_idx <= 16'd1;
          if (n != 16'd0) begin
            state     <= S_BURST;
            pg        <= 1'b1;
            core_rstz <= 1'b1;
          end else begin
            state <= S_PARK;
          end
        end
        S_BURST: begin
          if (rd_idx == n) begin
            state     <= S_PARK;
            pg        <= 1'b0;
            core_rstz <= 1'b0;
          end else begin
            rd_idx <= rd_idx + 16'd1;
          end
        end
        S_PARK: begin
          state     <= S_RUN;
          core_rstz <= 1'b1;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        S_RUN: state <= S_RUN;
        S_ERR: state <= S_ERR;
        default: begin
          state     <= S_ERR;
          err       <= 1'b1;
          busy      <= 1'b0;
          pg        <= 1'b0;
          core_rstz <= 1'b0;
          rx_ready  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA_LO && acc) begin
      mem[wr_idx[AW-1:0]] <= rx_word;
    end
  end

  // Read one word ahead so pg_instr lands together with each pg cycle.
  assign rd_en   = (state == S_ARM && n != 16'd0) || (state == S_BURST && rd_idx != n);
  assign rd_addr = (state == S_ARM) ? '0 : rd_idx[AW-1:0];

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      pg_instr <= '0;
    end else if (rd_en) begin
      pg_instr <= mem[rd_addr];
    end else begin
      pg_instr <= '0;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: random images streamed in, checked against a simple core model (PC + imem).
module tb_prog_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, pg, core_rstz, busy, done, err;
  logic [15:0] pg_instr;

  int compared = 0;
  int mismatched = 0;
  int edges;
  int rx_viol;
  logic [15:0] wq[$];
  logic [7:0]  bq[$];
  logic [15:0] imem [DEPTH];

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rstz(rstz), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pg(pg), .pg_instr(pg_instr), .core_rstz(core_rstz),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rstz = 1'b0;
    repeat (2) @(negedge clk);
    rstz = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input int n);
    wq.delete();
    repeat (n) wq.push_back(16'($urandom));
  endtask

  task automatic make_bytes(input logic [15:0] hdr);
    logic [15:0] s;
    s = '0;
    bq.delete();
    bq.push_back(hdr[15:8]);
    bq.push_back(hdr[7:0]);
    foreach (wq[i]) begin
      bq.push_back(wq[i][15:8]);
      bq.push_back(wq[i][7:0]);
      s = s + wq[i];
    end
`ifdef PROG_LOADER_CKSUM_EN
    bq.push_back(s[15:8]);
    bq.push_back(s[7:0]);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input int budget, output bit ok);
    ok = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      @(posedge clk);
      edges++;
    end
    for (int t = 0; t < budget && !ok; t++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = b;
      if (core_rstz !== 1'b0 || pg !== 1'b0) rx_viol++;
      ok = (rx_ready === 1'b1);
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic send_stream(input int gmin, input int gmax, output bit ok);
    bit b;
    ok = 1'b1;
    edges = 0;
    rx_viol = 0;
    foreach (bq[i]) begin
      send_byte(bq[i], $urandom_range(gmax, gmin), 4, b);
      if (!b) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  // Core model: reset parks PC at 0x8000, each pg cycle stores a word and advances PC by 2.
  task automatic observe(input string tag, input int n);
    int first = -1, last = -1, cnt = 0, broken = 0, done_at = -1, oob = 0, bad = 0;
    logic [15:0] pc = 16'h8000;
    logic [15:0] pc_done = 16'h0;
    logic arm_rst = 1'b1, park_rst = 1'b1, busy1 = 1'b0;
    foreach (imem[k]) imem[k] = 'x;
    for (int i = 1; i <= n + 6; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (i == 1) begin
        arm_rst = core_rstz;
        busy1 = busy;
      end
      if (last > 0 && i == last + 1) park_rst = core_rstz;
      if (pg === 1'b1) begin
        if (first < 0) first = i;
        else if (last != i - 1) broken++;
        last = i;
        cnt++;
      end
      if (core_rstz === 1'b0) pc = 16'h8000;
      else if (pg === 1'b1) begin
        if (pc >= 16'h8000 && int'(pc - 16'h8000) / 2 < DEPTH) imem[(pc - 16'h8000) >> 1] = pg_instr;
        else oob++;
        pc = pc + 16'd2;
      end
      if (done === 1'b1 && done_at < 0) begin
        done_at = i;
        pc_done = pc;
      end
    end
    for (int k = 0; k < n; k++) if (imem[k] !== wq[k]) bad++;
    check({tag, "_first_pg"}, first, (n > 0) ? 2 : -1);
    check({tag, "_pg_cycles"}, cnt, n);
    check({tag, "_pg_contig"}, broken, 0);
    check({tag, "_arm_rst"}, arm_rst, 0);
    check({tag, "_busy_arm"}, busy1, 1);
    if (n > 0) check({tag, "_park_rst"}, park_rst, 0);
    check({tag, "_done_lat"}, done_at, n + 3);
    check({tag, "_pc_run"}, pc_done, 16'h8000);
    check({tag, "_imem"}, bad, 0);
    check({tag, "_oob"}, oob, 0);
    check({tag, "_run_outs"}, {busy, err, rx_ready, core_rstz}, 4'b0001);
  endtask

  task automatic run_case(input string tag, input int gmin, input int gmax);
    bit ok;
    do_reset();
    make_bytes(16'(wq.size()));
    send_stream(gmin, gmax, ok);
    check({tag, "_send"}, ok, 1);
    check({tag, "_rx_core_held"}, rx_viol, 0);
    if (gmax == 0) check({tag, "_b2b"}, edges, bq.size());
    observe(tag, wq.size());
  endtask

  initial begin
    bit ok;
    int pgs;
    logic pre;
    rstz = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pg", pg, 0);
    check("rst_instr", pg_instr, 0);
    check("rst_core_rstz", core_rstz, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_rdy", rx_ready, 0);
    rstz = 1'b1;
    #1 check("rst_rdy_first", rx_ready, 0);
    @(negedge clk);
    check("rst_rdy_after", rx_ready, 1);

    wq.delete();
    wq.push_back(16'h1234); wq.push_back(16'hABCD); wq.push_back(16'h0001);
    run_case("spec", 0, 0);
    wq.delete();
    run_case("n0", 0, 0);
    fill(DEPTH);
    run_case("ndepth", 0, 0);
    fill(12);
    run_case("toggle", 1, 1);
    for (int t = 0; t < 6; t++) begin
      fill($urandom_range(40, 1));
      run_case($sformatf("rnd%0d", t), 0, (t % 2) * 3);
    end

    // Oversized header
    do_reset();
    send_byte(8'h01, 0, 4, ok);
    check("ovf_hdr_hi", ok, 1);
    send_byte(8'h01, 0, 4, ok);
    check("ovf_hdr_lo", ok, 1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("ovf_outs", {err, rx_ready, core_rstz, pg, busy}, 5'b10000);
    send_byte(8'hAA, 0, 6, ok);
    check("ovf_no_accept", ok, 0);
    pgs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (pg === 1'b1) pgs++;
    end
    check("ovf_no_pg", pgs, 0);
    check("ovf_err_sticky", err, 1);

`ifdef PROG_LOADER_CKSUM_EN
    do_reset();
    bq.delete();
    bq.push_back(8'h00); bq.push_back(8'h01); bq.push_back(8'h00);
    bq.push_back(8'h05); bq.push_back(8'h00); bq.push_back(8'h06);
    send_stream(0, 0, ok);
    check("ck_send", ok, 1);
    pgs = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (pg === 1'b1) pgs++;
    end
    check("ck_no_pg", pgs, 0);
    check("ck_err", {err, core_rstz, done}, 3'b100);
`endif

    // Reset while bursting
    do_reset();
    fill(20);
    make_bytes(16'(wq.size()));
    send_stream(0, 0, ok);
    check("mid_send", ok, 1);
    repeat (4) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    pre = pg;
    check("mid_pre_pg", pre, 1);
    #2 rstz = 1'b0;
    #1;
    check("mid_outs", {pg, core_rstz, done, busy, err}, 5'b00000);
    check("mid_instr", pg_instr, 0);
    fill(5);
    run_case("reload", 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that drives the core's programming port (`pg`, `pg_instr`) and its reset. It receives a byte stream (header, data words, optional checksum) over a valid/ready handshake and buffers the whole image internally. It then holds the core in reset and bursts the image into instruction memory at one word per cycle, starting at 0x8000. Finally it releases the core to run. It sits between the board-level byte source (UART RX) and the CPU top.

## Interface
- `DEPTH`, 256: buffer capacity in 16-bit words (power of two).
- `AW`, 8: buffer address width, log2(`DEPTH`).
- `clk`  in  1  single clock, rising edge.
- `rstz`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts byte; transfer on edge with `rx_valid & rx_ready`.
- `pg`  out  1  programming-mode strobe to core.
- `pg_instr`  out  16  instruction word to core.
- `core_rstz`  out  1  active-low reset to core (synchronous to `clk`, registered).
- `busy`  out  1  high from first header byte accepted until RUN or ERR.
- `done`  out  1  high in RUN.
- `err`  out  1  high in ERR (sticky until `rstz`).

## Operation
- Stream format, all big-endian (high byte first):
  - 16-bit word count N.
  - N data words.
  - With `PROG_LOADER_CKSUM_EN`, a 16-bit checksum word.
- States: HDR_HI, HDR_LO, DATA_HI, DATA_LO, [CK_HI, CK_LO], ARM, BURST, PARK, RUN, ERR.
- HDR_HI → HDR_LO on byte accept; N captured.
- From HDR_LO:
  - N > `DEPTH` → ERR.
  - N = 0 → ARM (or CK_HI if checksum enabled).
  - Otherwise → DATA_HI.
- DATA_HI / DATA_LO alternate. The word is written to `buf[wr_idx]` on the DATA_LO accept, then `wr_idx` increments.
- After word N−1: → CK_HI if checksum enabled, else → ARM.
- `rx_ready` = 1 only in HDR_*, DATA_*, CK_*; 0 elsewhere. `rx_valid` is ignored when `rx_ready` = 0.
- ARM: `core_rstz` = 0, so the core PC is forced to 0x8000. Buffer word 0 is read. → BURST if N > 0, else → PARK.
- BURST: `pg` = 1, `core_rstz` = 1, for exactly N consecutive cycles.
  - Cycle k presents `pg_instr` = `buf[k]`. The core writes it at 0x8000 + 2k and advances PC by 2.
  - No stall is possible. `pg` must never drop mid-burst.
- PARK: `pg` = 0, `core_rstz` = 0 for one cycle, which returns the core PC to 0x8000. → RUN.
- RUN: `core_rstz` = 1, `done` = 1. Terminal until `rstz`.
- ERR: `core_rstz` = 0, `pg` = 0, `err` = 1. Terminal until `rstz`.
- Buffer: single-port synchronous RAM, `DEPTH` × 16, 1-cycle read latency. Read address is prefetched so `pg_instr` is valid in each BURST cycle.

## Timing
- Reset values: state = HDR_HI, `rx_ready` = 0 in the reset cycle then 1, `pg` = 0, `pg_instr` = 0x0000, `core_rstz` = 0, `busy` = 0, `done` = 0, `err` = 0.
- `core_rstz` stays 0 through the entire receive phase.
- Back-to-back bytes: one byte per cycle is accepted, with no bubbles.
- Latency from the last byte accepted to first `pg` high: 2 cycles (ARM, then BURST cycle 0).
- Latency from last `pg` high to `done`: 2 cycles (PARK, then RUN).
- `pg` and `pg_instr` are registered outputs, with no combinational path from `rx_*`.
- N = `DEPTH`: allowed. `wr_idx` reaches `DEPTH` and does not wrap.
- N = `DEPTH`+1: ERR entered the cycle after the HDR_LO accept. Later bytes are not accepted.
- `rstz` asserted mid-burst: all outputs return to reset values immediately (asynchronously). Buffer contents are don't-care, and the stream must be resent from the header.

## Configuration
- `PROG_LOADER_CKSUM_EN` defined:
  - After the data, CK_HI/CK_LO receive a 16-bit checksum.
  - Compare it against the running sum of all data words mod 2^16 (N = 0 gives a sum of 0x0000).
  - Match → ARM. Mismatch → ERR, with no burst performed.
- Undefined: no checksum states exist. The last data word goes directly to ARM, and no trailer byte is accepted.

## Test plan
- Reset: hold `rstz` = 0 → `pg` = 0, `pg_instr` = 0x0000, `core_rstz` = 0, `done` = 0, `err` = 0. Release → `rx_ready` = 1.
- Stream 00 03 12 34 AB CD 00 01 (+ checksum BE 02 if enabled) → one cycle of `core_rstz` = 0, then three consecutive `pg` cycles with 0x1234, 0xABCD, 0x0001, then one cycle of reset, then `done` = 1 with the core PC at 0x8000.
- N = 0 (00 00, + 00 00 if checksum enabled) → no `pg` pulse; ARM, PARK, RUN in 3 cycles.
- Header 01 01 with `DEPTH` = 256 → `err` = 1, `rx_ready` = 0, `core_rstz` held at 0, no `pg`.
- `rx_valid` toggling every other cycle during data → words buffered correctly, and the burst is still N contiguous `pg` cycles.
- Checksum enabled, stream 00 01 00 05 00 06 → `err` = 1, no `pg`. `rstz` pulse during BURST → `pg` = 0 and `core_rstz` = 0 immediately.
